// File: rtl/bram_frame_sequencer.sv
// Frame sequencer for the time-multiplexed block RAM: one core request per frame, i1re -> i2re -> dre -> gwe.
// Optional perf counters (frame_cnt, stall_cnt) are compiled in with MEMSEQ_PERF_CNT_EN.
//
// state | meaning
// IDLE  | no frame in flight, ready for a request
// P_I1  | first instruction fetch strobe (i1re)
// P_I2  | second instruction fetch strobe (i2re), i1out valid
// P_D   | data read strobe (dre), single write for stores (dwe), i2out valid
// P_W   | closing phase (gwe), dout valid, ready for the next request
module bram_frame_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_W    = 16
) (
   input  logic                 idclk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_W-1:0]    req_i1addr,
   input  logic [ADDR_W-1:0]    req_i2addr,
   input  logic [ADDR_W-1:0]    req_daddr,
   input  logic [WORD_SIZE-1:0] req_din,
   input  logic                 req_dwe,
   output logic                 i1re,
   output logic                 i2re,
   output logic                 dre,
   output logic                 gwe,
   output logic [ADDR_W-1:0]    i1addr,
   output logic [ADDR_W-1:0]    i2addr,
   output logic [ADDR_W-1:0]    daddr,
   output logic [WORD_SIZE-1:0] din,
   output logic                 dwe,
   input  logic [15:0]          i1out,
   input  logic [15:0]          i2out,
   input  logic [WORD_SIZE-1:0] dout,
   output logic                 rsp_valid,
   output logic [15:0]          rsp_insn1,
   output logic [15:0]          rsp_insn2,
   output logic [WORD_SIZE-1:0] rsp_ddata
`ifdef MEMSEQ_PERF_CNT_EN
   ,
   output logic [31:0]          frame_cnt,
   output logic [31:0]          stall_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, P_I1, P_I2, P_D, P_W} state_t;

   state_t state;
   state_t state_nxt;
   logic   dwe_hold;
   logic   accept;

   assign req_ready = (state == IDLE) || (state == P_W);
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = req_valid ? P_I1 : IDLE;
         P_I1:    state_nxt = P_I2;
         P_I2:    state_nxt = P_D;
         P_D:     state_nxt = P_W;
         P_W:     state_nxt = req_valid ? P_I1 : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state register.
   always_ff @(posedge idclk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         i1re      <= 1'b0;
         i2re      <= 1'b0;
         dre       <= 1'b0;
         gwe       <= 1'b0;
         dwe       <= 1'b0;
         dwe_hold  <= 1'b0;
         i1addr    <= '0;
         i2addr    <= '0;
         daddr     <= '0;
         din       <= '0;
         rsp_valid <= 1'b0;
         rsp_insn1 <= '0;
         rsp_insn2 <= '0;
         rsp_ddata <= '0;
      end else begin
         state     <= state_nxt;
         i1re      <= (state_nxt == P_I1);
         i2re      <= (state_nxt == P_I2);
         dre       <= (state_nxt == P_D);
         gwe       <= (state_nxt == P_W);
         // dwe_hold was loaded two edges before entering P_D, so it is already stable here.
         dwe       <= (state_nxt == P_D) && dwe_hold;
         rsp_valid <= (state == P_W);
         if (accept) begin
            i1addr   <= req_i1addr;
            i2addr   <= req_i2addr;
            daddr    <= req_daddr;
            din      <= req_din;
            dwe_hold <= req_dwe;
         end
         if (state == P_I2) rsp_insn1 <= i1out;
         if (state == P_D)  rsp_insn2 <= i2out;
         if (state == P_W)  rsp_ddata <= dwe_hold ? '0 : dout;
      end
   end

`ifdef MEMSEQ_PERF_CNT_EN
   always_ff @(posedge idclk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (rsp_valid && (frame_cnt != 32'hFFFF_FFFF)) frame_cnt <= frame_cnt + 32'd1;
         if ((state == IDLE) && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bram_frame_sequencer.sv
// Self-checking bench for bram_frame_sequencer: frame-level model plus directed scenarios.
// Perf counter checks are compiled in with MEMSEQ_PERF_CNT_EN.
module tb_bram_frame_sequencer;

   logic        idclk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_i1addr = '0, req_i2addr = '0, req_daddr = '0, req_din = '0;
   logic        req_dwe = 1'b0;
   logic        i1re, i2re, dre, gwe, dwe;
   logic [15:0] i1addr, i2addr, daddr, din;
   logic [15:0] i1out = '0, i2out = '0, dout = '0;
   logic        rsp_valid;
   logic [15:0] rsp_insn1, rsp_insn2, rsp_ddata;
`ifdef MEMSEQ_PERF_CNT_EN
   logic [31:0] frame_cnt, stall_cnt;
`endif

   bram_frame_sequencer #(.WORD_SIZE(16), .ADDR_W(16)) dut (
      .idclk(idclk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_i1addr(req_i1addr), .req_i2addr(req_i2addr), .req_daddr(req_daddr),
      .req_din(req_din), .req_dwe(req_dwe),
      .i1re(i1re), .i2re(i2re), .dre(dre), .gwe(gwe),
      .i1addr(i1addr), .i2addr(i2addr), .daddr(daddr), .din(din), .dwe(dwe),
      .i1out(i1out), .i2out(i2out), .dout(dout),
      .rsp_valid(rsp_valid), .rsp_insn1(rsp_insn1), .rsp_insn2(rsp_insn2), .rsp_ddata(rsp_ddata)
`ifdef MEMSEQ_PERF_CNT_EN
      , .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 idclk = ~idclk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge idclk) cyc <= cyc + 1;

   // Synchronous-read RAM: outputs appear the cycle after their strobe.
   logic [15:0] ram_i  [0:65535];
   logic [15:0] ram_d  [0:65535];
   logic [15:0] gold_d [0:65535];

   always @(posedge idclk) begin
      if (i1re) i1out <= ram_i[i1addr];
      if (i2re) i2out <= ram_i[i2addr];
      if (dre)  dout  <= ram_d[daddr];
      if (dwe)  ram_d[daddr] = din;
   end

   // Frame-level model: a frame accepted before cycle s owns strobe k in cycle s+k, responds in s+4.
   typedef struct {
      int          s;
      logic [15:0] a1, a2, ad, dn, ed;
      logic        we;
   } frame_t;
   frame_t q[$];
   int idle_seen = 0;

   always @(negedge idclk) begin
      logic [3:0] es;
      logic       er, ev, edwe;
      int         k;
      frame_t     f;
      if (!rst) begin
         q.delete();
         chk("reset_outputs", {26'd0, i1re, i2re, dre, gwe, dwe, rsp_valid}, 32'd0);
         chk("reset_ready", {31'd0, req_ready}, 32'd1);
      end else begin
         es = 4'b0; er = 1'b1; ev = 1'b0; edwe = 1'b0;
         foreach (q[i]) begin
            k = cyc - q[i].s;
            if (k <= 3) begin
               es[3-k] = 1'b1;
               chk("i1addr", {16'd0, i1addr}, {16'd0, q[i].a1});
               chk("i2addr", {16'd0, i2addr}, {16'd0, q[i].a2});
               chk("daddr",  {16'd0, daddr},  {16'd0, q[i].ad});
               chk("din",    {16'd0, din},    {16'd0, q[i].dn});
            end
            if (k <= 2) er = 1'b0;
            if (k == 2) begin
               edwe     = q[i].we;
               q[i].ed  = q[i].we ? 16'h0000 : gold_d[q[i].ad];
               if (q[i].we) gold_d[q[i].ad] = q[i].dn;
            end
            if (k == 4) begin
               ev = 1'b1;
               chk("rsp_insn1", {16'd0, rsp_insn1}, {16'd0, ram_i[q[i].a1]});
               chk("rsp_insn2", {16'd0, rsp_insn2}, {16'd0, ram_i[q[i].a2]});
               chk("rsp_ddata", {16'd0, rsp_ddata}, {16'd0, q[i].ed});
            end
         end
         chk("strobes",   {28'd0, i1re, i2re, dre, gwe}, {28'd0, es});
         chk("req_ready", {31'd0, req_ready}, {31'd0, er});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
         chk("dwe",       {31'd0, dwe},       {31'd0, edwe});
         if (es == 4'b0) idle_seen++;
         while (q.size() > 0 && (cyc - q[0].s) >= 4) void'(q.pop_front());
         if (req_valid && er) begin
            f.s = cyc + 1; f.a1 = req_i1addr; f.a2 = req_i2addr; f.ad = req_daddr;
            f.dn = req_din; f.we = req_dwe; f.ed = '0;
            q.push_back(f);
         end
      end
   end

   // Response / write-enable monitor feeding the literal checks.
   int          rsp_cnt = 0;
   int          dwe_cnt = 0;
   int          rsp_cycs[$];
   logic [15:0] rsp_d[$];
   logic [15:0] last_i1, last_i2;
   always @(negedge idclk) begin
      if (rst && rsp_valid) begin
         rsp_cnt++;
         rsp_cycs.push_back(cyc);
         rsp_d.push_back(rsp_ddata);
         last_i1 = rsp_insn1;
         last_i2 = rsp_insn2;
      end
      if (rst && dwe) dwe_cnt++;
   end

   int acc_cyc;
   task automatic send_req(input logic [15:0] a1, a2, ad, dn, input logic we);
      int ok = 0;
      int n  = 0;
      req_valid = 1'b1; req_i1addr = a1; req_i2addr = a2; req_daddr = ad;
      req_din = dn; req_dwe = we;
      while (ok == 0 && n < 20) begin
         @(negedge idclk);
         if (req_ready) ok = 1;
         @(posedge idclk); #1;
         n++;
      end
      chk("req_accept", ok, 1);
      acc_cyc = cyc;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge idclk);
      #1;
   endtask

   int base, dbase;

   initial begin
      for (int a = 0; a < 65536; a++) begin
         ram_i[a] = '0; ram_d[a] = '0; gold_d[a] = '0;
      end
      ram_i[16'h0010] = 16'h1234; ram_i[16'h0011] = 16'hABCD; ram_i[16'hFFFF] = 16'h7E57;
      ram_d[16'h0200] = 16'h5A5A; gold_d[16'h0200] = 16'h5A5A;
      ram_d[16'hFFFF] = 16'hC0DE; gold_d[16'hFFFF] = 16'hC0DE;

      #1;
      chk("reset_rsp_insn1", {16'd0, rsp_insn1}, 32'd0);
      chk("reset_i1addr",    {16'd0, i1addr},    32'd0);
      chk("reset_rsp_ddata", {16'd0, rsp_ddata}, 32'd0);
      repeat (2) @(posedge idclk);
      #1 rst = 1'b1;

      idle(5);
      chk("idle_no_rsp", rsp_cnt, 0);

      // Single load frame
      send_req(16'h0010, 16'h0011, 16'h0200, 16'h0000, 1'b0);
      idle(6);
      chk("load_rsp_count", rsp_cnt, 1);
      chk("load_latency", rsp_cycs[rsp_cycs.size()-1] - acc_cyc, 4);
      chk("load_insn1", {16'd0, last_i1}, 32'h1234);
      chk("load_insn2", {16'd0, last_i2}, 32'hABCD);
      chk("load_ddata", {16'd0, rsp_d[rsp_d.size()-1]}, 32'h5A5A);

      // Store then load to the same address, back to back
      base = rsp_cnt; dbase = dwe_cnt;
      send_req(16'h0011, 16'h0010, 16'h0300, 16'hBEEF, 1'b1);
      send_req(16'h0010, 16'h0011, 16'h0300, 16'h0000, 1'b0);
      idle(8);
      chk("st_ld_rsp_count", rsp_cnt - base, 2);
      chk("store_ddata_zero", {16'd0, rsp_d[base]}, 32'h0000);
      chk("load_after_store", {16'd0, rsp_d[base+1]}, 32'hBEEF);
      chk("store_single_dwe", dwe_cnt - dbase, 1);
      chk("ram_store", {16'd0, ram_d[16'h0300]}, 32'hBEEF);

      // Three frames with req_valid held high, including the top address
      base = rsp_cnt;
      send_req(16'hFFFF, 16'h0010, 16'hFFFF, 16'h0000, 1'b0);
      send_req(16'h0011, 16'hFFFF, 16'h0200, 16'h0000, 1'b0);
      send_req(16'h0010, 16'h0011, 16'h0300, 16'h0000, 1'b0);
      idle(8);
      chk("b2b_rsp_count", rsp_cnt - base, 3);
      chk("b2b_gap1", rsp_cycs[base+1] - rsp_cycs[base], 4);
      chk("b2b_gap2", rsp_cycs[base+2] - rsp_cycs[base+1], 4);
      chk("b2b_wrap_ddata", {16'd0, rsp_d[base]}, 32'hC0DE);

      // Reset during P_I2 of a store frame
      base = rsp_cnt;
      send_req(16'h0010, 16'h0011, 16'h0400, 16'h1111, 1'b1);
      req_valid = 1'b0;
      @(posedge idclk);
      #2 rst = 1'b0;
      #1;
      chk("async_strobes", {28'd0, i1re, i2re, dre, gwe}, 32'd0);
      chk("async_dwe", {31'd0, dwe}, 32'd0);
      repeat (2) @(posedge idclk);
      #1 rst = 1'b1;
      idle(4);
      chk("abort_no_rsp", rsp_cnt - base, 0);
      chk("abort_store_lost", {16'd0, ram_d[16'h0400]}, 32'h0000);
      send_req(16'h0011, 16'h0010, 16'h0200, 16'h0000, 1'b0);
      idle(6);
      chk("post_reset_rsp", rsp_cnt - base, 1);
      chk("post_reset_insn1", {16'd0, last_i1}, 32'hABCD);

`ifdef MEMSEQ_PERF_CNT_EN
      @(posedge idclk); #1 rst = 1'b0;
      @(posedge idclk); #1;
      chk("perf_reset_frames", frame_cnt, 0);
      chk("perf_reset_stall", stall_cnt, 0);
      idle_seen = 0;
      rst = 1'b1;
      for (int f = 0; f < 3; f++) begin
         send_req(16'h0010, 16'h0011, 16'h0200, 16'h0000, 1'b0);
         idle(5);
      end
      idle(3);
      chk("perf_frame_cnt", frame_cnt, 3);
      chk("perf_stall_cnt", stall_cnt, idle_seen);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bram_frame_sequencer.md
Name: bram_frame_sequencer

Overview:
- Upstream driver of the time-multiplexed block RAM.
- Accepts one memory request per frame from the core: two instruction fetches plus one data read or write.
- Generates the strictly ordered strobes i1re -> i2re -> dre -> gwe on idclk, holds addresses and data stable for the frame, and captures the RAM outputs in the cycle each is valid.
- Returns one response per frame to the core through a valid/ready handshake.

Parameters:
- WORD_SIZE, 16, data word width (din/dout/rsp_ddata).
- ADDR_W, 16, address width for all three address ports.

Ports:
- idclk  in  1  single clock, shared with the RAM.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  1  core has a frame request.
- req_ready  out  1  sequencer accepts a request this cycle.
- req_i1addr  in  ADDR_W  first instruction fetch address.
- req_i2addr  in  ADDR_W  second instruction fetch address.
- req_daddr  in  ADDR_W  data address.
- req_din  in  WORD_SIZE  store data.
- req_dwe  in  1  1 = store, 0 = load.
- i1re, i2re, dre, gwe  out  1 each  RAM phase strobes, one-hot or all zero.
- i1addr, i2addr, daddr  out  ADDR_W  registered RAM addresses.
- din  out  WORD_SIZE  registered store data.
- dwe  out  1  RAM data write enable.
- i1out, i2out  in  16  RAM instruction outputs.
- dout  in  WORD_SIZE  RAM data output.
- rsp_valid  out  1  one-cycle pulse; response fields valid.
- rsp_insn1, rsp_insn2  out  16  captured instructions.
- rsp_ddata  out  WORD_SIZE  captured load data (stores return 0).

Behaviour:
- FSM states: IDLE, P_I1, P_I2, P_D, P_W. Strobes are Moore outputs of the state:
  - P_I1 -> i1re=1
  - P_I2 -> i2re=1
  - P_D -> dre=1
  - P_W -> gwe=1
  - IDLE -> all strobes 0
- Transitions:
  - IDLE: if req_valid, go to P_I1; else stay in IDLE.
  - P_I1 -> P_I2 -> P_D -> P_W unconditionally.
  - P_W: if req_valid, go to P_I1 (back-to-back frames with no gap); else go to IDLE.
- req_ready = (state==IDLE) || (state==P_W), combinational. A request is accepted on any edge where req_valid && req_ready.
- On acceptance, register i1addr/i2addr/daddr/din/dwe_hold. They stay constant through P_I1..P_W and are never changed mid-frame.
- dwe = dwe_hold && (state==P_D). This gives exactly one RAM write per store frame. dwe is never high in any other state.
- Capture points:
  - rsp_insn1 <= i1out on the edge leaving P_I2.
  - rsp_insn2 <= i2out on the edge leaving P_D.
  - rsp_ddata <= (dwe_hold ? 0 : dout) on the edge leaving P_W.
- rsp_valid = 1 for exactly one cycle, the cycle after P_W (state P_I1 or IDLE).
- Latency: acceptance edge to rsp_valid high is 4 idclk cycles.
- Response fields hold their values until overwritten by the next frame's capture.
- Reset (rst=0, asynchronous): state=IDLE; all strobes, dwe and rsp_valid go to 0 immediately; all address, data and response registers go to 0.
- Reset mid-frame: the frame is abandoned with no rsp_valid. A store is lost if reset occurs before P_D.
- req_valid dropping in any state other than IDLE/P_W has no effect (not sampled).
- Address wrap-around: none. Addresses pass through unmodified; 16'hFFFF is legal.

Optional Feature:
- Macro: MEMSEQ_PERF_CNT_EN.
- When defined, two extra outputs exist:
  - frame_cnt[31:0]: increments on each rsp_valid.
  - stall_cnt[31:0]: increments each cycle in IDLE while rst=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then hold req_valid=0 for 5 cycles -> state IDLE, all strobes 0, rsp_valid never asserted.
- RAM image i[0x0010]=0x1234, i[0x0011]=0xABCD, d[0x0200]=0x5A5A; single load request (0x0010, 0x0011, 0x0200, dwe=0) -> strobes i1re, i2re, dre, gwe in consecutive cycles; rsp_valid 4 cycles after acceptance with insn1=0x1234, insn2=0xABCD, ddata=0x5A5A.
- Store request daddr=0x0300, din=0xBEEF, then a load frame to 0x0300 -> dwe high only in the store frame's dre cycle; second response ddata=0xBEEF; first response ddata=0.
- req_valid held high for 3 frames -> strobes rotate with no idle cycle; rsp_valid pulses every 4 cycles; req_ready high only in gwe cycles (and the initial IDLE).
- Assert rst=0 asynchronously during the P_I2 cycle of a store frame -> strobes drop in the same cycle; no rsp_valid; d[daddr] unchanged; after release, a new request completes normally.
- With MEMSEQ_PERF_CNT_EN, run 3 frames with 2 idle cycles between them -> frame_cnt=3, stall_cnt equals the total IDLE cycles counted after reset release.
